// File: rtl/uart_tx_frame.sv
// Parametrised UART serializer: start bit, DATA_W data bits LSB first, optional parity, stop bits.
// Define UART_TX_PARITY_EN to build the PARITY state and the runtime parity_en/parity_odd controls.
module uart_tx_frame #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned OVS       = 16,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              b_tick,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              parity_en,
  input  logic              parity_odd,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx
);

  localparam int unsigned TW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int unsigned BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [TW-1:0] TickLast = TW'(OVS - 1);
  localparam logic [BW-1:0] DataLast = BW'(DATA_W - 1);
  localparam logic [BW-1:0] StopLast = BW'(STOP_BITS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] StParity = 3'd3;
`endif
  localparam logic [2:0] StStop   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [BW-1:0]     bit_inc;
  logic [DATA_W-1:0] data_q, data_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;
  logic              accept;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_odd_q, par_odd_d;
  logic par_bit;

  assign par_bit = (^data_q) ^ par_odd_q;
`else
  logic unused_parity;

  assign unused_parity = parity_en ^ parity_odd;
`endif

  assign bit_end = b_tick && (tick_q == TickLast);
  assign bit_inc = bit_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    accept  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
`endif

    if (b_tick && (state_q != StIdle)) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        accept = tx_start;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = data_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == DataLast) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = par_bit;
            end else begin
`else
            begin
`endif
              state_d = StStop;
              bit_d   = '0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_inc;
            tx_d  = data_q[bit_inc];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (bit_q == StopLast) begin
            // Final stop edge doubles as an accept window for gap-free frames.
            done_d = 1'b1;
            accept = tx_start;
            if (!tx_start) begin
              state_d = StIdle;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_inc;
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase

    if (accept) begin
      state_d = StStart;
      tick_d  = '0;
      bit_d   = '0;
      data_d  = tx_data;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_d  = parity_en;
      par_odd_d = parity_odd;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
    end
  end
`endif

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: default instance plus a 7-bit / OVS 8 / 2-stop instance,
// line checked tick by tick against an expected bit list built from the frame format.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       b_tick = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] data_a = '0;
  logic [6:0] data_b = '0;
  logic       pen = 1'b0;
  logic       podd = 1'b0;
  logic       busy_a, done_a, tx_a;
  logic       busy_b, done_b, tx_b;

  int total = 0;
  int bad = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int div = 0;

  uart_tx_frame dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .b_tick    (b_tick),
    .tx_start  (start_a),
    .tx_data   (data_a),
    .parity_en (pen),
    .parity_odd(podd),
    .tx_busy   (busy_a),
    .tx_done   (done_a),
    .tx        (tx_a)
  );

  uart_tx_frame #(
    .DATA_W   (7),
    .OVS      (8),
    .STOP_BITS(2)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .b_tick    (b_tick),
    .tx_start  (start_b),
    .tx_data   (data_b),
    .parity_en (pen),
    .parity_odd(podd),
    .tx_busy   (busy_b),
    .tx_done   (done_b),
    .tx        (tx_b)
  );

  always #5 clk = ~clk;

  // b_tick: one clk high every 4 clks, changed away from the rising edge.
  always @(negedge clk) begin
    div = (div + 1) % 4;
    b_tick = (div == 0);
  end

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  // Expected line values, one entry per bit period.
  task automatic build_bits(input logic [8:0] d, input int w, input bit pe, input bit po,
                            input int stops, output logic [15:0] bits, output int n);
    logic [8:0] m;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < w; i++) bits[1 + i] = d[i];
    n = 1 + w;
`ifdef UART_TX_PARITY_EN
    if (pe) begin
      m = (9'd1 << w) - 9'd1;
      bits[n] = po ^ (($countones(d & m) % 2) == 1);
      n++;
    end
`endif
    n += stops;
  endtask

  task automatic next_tick();
    int g = 0;
    do begin
      @(posedge clk);
      g++;
    end while (b_tick !== 1'b1 && g < 20);
    #1;
    if (g >= 20) begin
      total++;
      bad++;
      $display("FAIL tick_timeout got=none want=b_tick within 20 clk");
    end
  endtask

  task automatic send(input bit sel, input logic [8:0] d, input bit pe, input bit po,
                      input bit hold);
    @(negedge clk);
    pen = pe;
    podd = po;
    if (sel) begin
      start_b = 1'b1;
      data_b = d[6:0];
    end else begin
      start_a = 1'b1;
      data_a = d[7:0];
    end
    @(posedge clk);
    #1;
    total++;
    if ((sel ? tx_b : tx_a) !== 1'b0) begin
      bad++;
      $display("FAIL accept_tx got=%b want=0", sel ? tx_b : tx_a);
    end
    total++;
    if ((sel ? busy_b : busy_a) !== 1'b1) begin
      bad++;
      $display("FAIL accept_busy got=%b want=1", sel ? busy_b : busy_a);
    end
    if (!hold) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      // Inputs change after accept; the frame must keep its latched copies.
      pen = ~pe;
      podd = ~po;
      data_a = ~d[7:0];
      data_b = ~d[6:0];
    end
  endtask

  // Checks the frame tick by tick after its accept edge. inj: tick after which a stray
  // 0xFF request is pulsed (0 = none). b2b: a new frame is expected on the final edge.
  task automatic check_frame(input bit sel, input logic [8:0] d, input bit pe, input bit po,
                             input bit b2b, input int inj);
    logic [15:0] bits;
    int n, ovs, nt, d0;
    logic exp_tx, exp_busy, exp_done, got_tx, got_busy, got_done;
    ovs = sel ? 8 : 16;
    build_bits(d, sel ? 7 : 8, pe, po, sel ? 2 : 1, bits, n);
    nt = n * ovs;
    d0 = sel ? done_cnt_b : done_cnt_a;
    for (int k = 1; k <= nt; k++) begin
      next_tick();
      exp_tx   = (k < nt) ? bits[k / ovs] : !b2b;
      exp_busy = (k < nt) || b2b;
      exp_done = (k == nt);
      got_tx   = sel ? tx_b : tx_a;
      got_busy = sel ? busy_b : busy_a;
      got_done = sel ? done_b : done_a;
      total++;
      if (got_tx !== exp_tx) begin
        bad++;
        $display("FAIL frame_tx d=%h tick=%0d got=%b want=%b", d, k, got_tx, exp_tx);
      end
      total++;
      if (got_busy !== exp_busy) begin
        bad++;
        $display("FAIL frame_busy d=%h tick=%0d got=%b want=%b", d, k, got_busy, exp_busy);
      end
      total++;
      if (got_done !== exp_done) begin
        bad++;
        $display("FAIL frame_done d=%h tick=%0d got=%b want=%b", d, k, got_done, exp_done);
      end
      if (k == inj) begin
        @(negedge clk);
        start_a = 1'b1;
        data_a = 8'hFF;
        @(negedge clk);
        start_a = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    total++;
    if ((sel ? done_cnt_b : done_cnt_a) - d0 != 1) begin
      bad++;
      $display("FAIL done_count d=%h got=%0d want=1", d,
               (sel ? done_cnt_b : done_cnt_a) - d0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({tx_a, busy_a, done_a} !== 3'b100) begin
      bad++;
      $display("FAIL reset_a got=%b want=100", {tx_a, busy_a, done_a});
    end
    total++;
    if ({tx_b, busy_b, done_b} !== 3'b100) begin
      bad++;
      $display("FAIL reset_b got=%b want=100", {tx_b, busy_b, done_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    send(0, 9'h0A5, 0, 0, 0);
    check_frame(0, 9'h0A5, 0, 0, 0, 0);
  endtask

  task automatic test_parity();
    send(0, 9'h0A5, 1, 0, 0);
    check_frame(0, 9'h0A5, 1, 0, 0, 0);
    send(0, 9'h0A5, 1, 1, 0);
    check_frame(0, 9'h0A5, 1, 1, 0, 0);
  endtask

  task automatic test_cfg2();
    logic [8:0] d;
    send(1, 9'h07F, 0, 0, 0);
    check_frame(1, 9'h07F, 0, 0, 0, 0);
    d = 9'($urandom) & 9'h07F;
    send(1, d, 0, 0, 0);
    check_frame(1, d, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    send(0, 9'h055, 0, 0, 1);
    @(negedge clk);
    data_a = 8'h0F;
    check_frame(0, 9'h055, 0, 0, 1, 0);
    start_a = 1'b0;
    check_frame(0, 9'h00F, 0, 0, 0, 0);
  endtask

  task automatic test_ignore_start();
    send(0, 9'h000, 0, 0, 0);
    check_frame(0, 9'h000, 0, 0, 0, 16 * 3 + 5);
  endtask

  task automatic test_reset_mid();
    int d0;
    send(0, 9'h0C3, 0, 0, 0);
    for (int k = 1; k <= 16 * 4 + 5; k++) next_tick();
    d0 = done_cnt_a;
    rst_n = 1'b0;
    #1;
    total++;
    if (tx_a !== 1'b1) begin
      bad++;
      $display("FAIL midreset_tx got=%b want=1", tx_a);
    end
    total++;
    if (busy_a !== 1'b0) begin
      bad++;
      $display("FAIL midreset_busy got=%b want=0", busy_a);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (done_cnt_a != d0) begin
      bad++;
      $display("FAIL midreset_done got=%0d want=0", done_cnt_a - d0);
    end
    send(0, 9'h03C, 0, 0, 0);
    check_frame(0, 9'h03C, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [8:0] d;
    bit pe, po;
    for (int i = 0; i < 6; i++) begin
      d = 9'($urandom) & 9'h0FF;
      pe = 1'($urandom);
      po = 1'($urandom);
      repeat ($urandom_range(0, 9)) @(negedge clk);
      send(0, d, pe, po, 0);
      check_frame(0, d, pe, po, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_cfg2();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
